// File: rtl/user_data_ram.sv
// Dual-read-port data RAM that preloads itself from INIT_VALUES after reset.
// Optional macro USER_DATA_RELOAD_EN adds a reload port that reruns the preload.
module user_data_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_VALUES =
    (DEPTH*DATA_WIDTH)'(8'hBB) | ((DEPTH*DATA_WIDTH)'(8'h77) << DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  ready
`ifdef USER_DATA_RELOAD_EN
  ,
  input  logic                  reload
`endif
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_load_ptr;
  logic [ADDR_WIDTH-1:0] w_load_ptr_next;
  logic                  r_ready;
  logic                  w_ready_next;
  logic                  w_reload;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_init_word [DEPTH];

`ifdef USER_DATA_RELOAD_EN
  assign w_reload = reload;
`else
  assign w_reload = 1'b0;
`endif

  // Unpack the flat preload vector so the load path is a plain array lookup.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
      assign w_init_word[gi] = INIT_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_load_ptr <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_load_ptr <= w_load_ptr_next;
      r_ready    <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_load_ptr_next = r_load_ptr;
    w_mem_we        = 1'b0;
    w_mem_addr      = waddr;
    w_mem_wdata     = wdata;
    case (r_state)
      ST_LOAD: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_load_ptr;
        w_mem_wdata = w_init_word[r_load_ptr];
        // Pointer parks on the last word; only reset or reload rewinds it.
        if (r_load_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_next = ST_RUN;
        end else begin
          w_load_ptr_next = r_load_ptr + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (w_reload) begin
          w_state_next    = ST_LOAD;
          w_load_ptr_next = '0;
        end else begin
          w_mem_we = we;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
    if (reset) begin
      w_mem_we = 1'b0;
    end
    w_ready_next = (w_state_next == ST_RUN);
  end

  // Contents are never cleared; the preload defines them.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign ready    = r_ready;
  assign rdata    = r_ready ? r_mem[raddr]    : '0;
  assign dbg_data = r_ready ? r_mem[dbg_addr] : '0;

endmodule
